// File: rtl/decode_stage_if.sv
// Fetch/writeback/flush inputs and ID/EX pipeline-register outputs of the decode stage.
// slave = decode stage side, master = surrounding pipeline (or bench) side.
interface decode_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CTRL_W = 4
);
    logic              IF_valid;
    logic              IF_ready;
    logic [ADDR_W-1:0] IF_addr_a;
    logic [ADDR_W-1:0] IF_addr_b;
    logic [ADDR_W-1:0] IF_addr_write;
    logic              IF_sig_write;
    logic              IF_sig_memread;
    logic [CTRL_W-1:0] IF_ctrl;

    logic [DATA_W-1:0] WB_data_write;
    logic [ADDR_W-1:0] WB_addr_write;
    logic              WB_sig_write;

    logic              EX_flush;

    logic              ID_valid;
    logic [DATA_W-1:0] ID_data_a;
    logic [DATA_W-1:0] ID_data_b;
    logic [ADDR_W-1:0] ID_addr_a;
    logic [ADDR_W-1:0] ID_addr_b;
    logic [ADDR_W-1:0] ID_addr_write;
    logic              ID_sig_write;
    logic              ID_sig_memread;
    logic [CTRL_W-1:0] ID_ctrl;

    modport slave (
        input  IF_valid, IF_addr_a, IF_addr_b, IF_addr_write, IF_sig_write,
               IF_sig_memread, IF_ctrl, WB_data_write, WB_addr_write,
               WB_sig_write, EX_flush,
        output IF_ready, ID_valid, ID_data_a, ID_data_b, ID_addr_a, ID_addr_b,
               ID_addr_write, ID_sig_write, ID_sig_memread, ID_ctrl
    );

    modport master (
        output IF_valid, IF_addr_a, IF_addr_b, IF_addr_write, IF_sig_write,
               IF_sig_memread, IF_ctrl, WB_data_write, WB_addr_write,
               WB_sig_write, EX_flush,
        input  IF_ready, ID_valid, ID_data_a, ID_data_b, ID_addr_a, ID_addr_b,
               ID_addr_write, ID_sig_write, ID_sig_memread, ID_ctrl
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, load-use stall, ID/EX register.
// Optional macro ZERO_REG_EN hardwires r0 to zero and suppresses writes/hazards on r0.
module decode_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CTRL_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] rf_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (ZERO_REG && addr == '0) return '0;
        if (we && waddr == addr) return wdata;
        return stored;
    endfunction

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              rf_we;
    logic              hazard;
    logic              dst_live;

    logic              vld_p1;
    logic [DATA_W-1:0] data_a_p1, data_b_p1;
    logic [ADDR_W-1:0] addr_a_p1, addr_b_p1, addr_write_p1;
    logic              sig_write_p1, sig_memread_p1;
    logic [CTRL_W-1:0] ctrl_p1;

    logic              vld_d;
    logic [DATA_W-1:0] data_a_d, data_b_d;
    logic [ADDR_W-1:0] addr_a_d, addr_b_d, addr_write_d;
    logic              sig_write_d, sig_memread_d;
    logic [CTRL_W-1:0] ctrl_d;

    // p0: register read, hazard detection, next-state selection
    always_comb begin
        rf_we    = bus.WB_sig_write && !(ZERO_REG && bus.WB_addr_write == '0);
        rd_a     = rf_read(bus.IF_addr_a, regs[bus.IF_addr_a], bus.WB_sig_write,
                           bus.WB_addr_write, bus.WB_data_write);
        rd_b     = rf_read(bus.IF_addr_b, regs[bus.IF_addr_b], bus.WB_sig_write,
                           bus.WB_addr_write, bus.WB_data_write);
        // A load writing r0 can never produce a value a consumer depends on.
        dst_live = !(ZERO_REG && addr_write_p1 == '0);
        hazard   = bus.IF_valid && vld_p1 && sig_memread_p1 && sig_write_p1 && dst_live &&
                   (addr_write_p1 == bus.IF_addr_a || addr_write_p1 == bus.IF_addr_b);
    end

    assign bus.IF_ready = !hazard || bus.EX_flush;

    always_comb begin
        vld_d         = 1'b0;
        data_a_d      = '0;
        data_b_d      = '0;
        addr_a_d      = '0;
        addr_b_d      = '0;
        addr_write_d  = '0;
        sig_write_d   = 1'b0;
        sig_memread_d = 1'b0;
        ctrl_d        = '0;
        if (!bus.EX_flush && !hazard && bus.IF_valid) begin
            vld_d         = 1'b1;
            data_a_d      = rd_a;
            data_b_d      = rd_b;
            addr_a_d      = bus.IF_addr_a;
            addr_b_d      = bus.IF_addr_b;
            addr_write_d  = bus.IF_addr_write;
            sig_write_d   = bus.IF_sig_write && !(ZERO_REG && bus.IF_addr_write == '0);
            sig_memread_d = bus.IF_sig_memread;
            ctrl_d        = bus.IF_ctrl;
        end
    end

    // Writeback is never stalled by decode, so the file writes even during a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[bus.WB_addr_write] <= bus.WB_data_write;
        end
    end

    // p1: ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            data_a_p1      <= '0;
            data_b_p1      <= '0;
            addr_a_p1      <= '0;
            addr_b_p1      <= '0;
            addr_write_p1  <= '0;
            sig_write_p1   <= 1'b0;
            sig_memread_p1 <= 1'b0;
            ctrl_p1        <= '0;
        end else begin
            vld_p1         <= vld_d;
            data_a_p1      <= data_a_d;
            data_b_p1      <= data_b_d;
            addr_a_p1      <= addr_a_d;
            addr_b_p1      <= addr_b_d;
            addr_write_p1  <= addr_write_d;
            sig_write_p1   <= sig_write_d;
            sig_memread_p1 <= sig_memread_d;
            ctrl_p1        <= ctrl_d;
        end
    end

    assign bus.ID_valid       = vld_p1;
    assign bus.ID_data_a      = data_a_p1;
    assign bus.ID_data_b      = data_b_p1;
    assign bus.ID_addr_a      = addr_a_p1;
    assign bus.ID_addr_b      = addr_b_p1;
    assign bus.ID_addr_write  = addr_write_p1;
    assign bus.ID_sig_write   = sig_write_p1;
    assign bus.ID_sig_memread = sig_memread_p1;
    assign bus.ID_ctrl        = ctrl_p1;
endmodule
